ccd_pixel_packer: RTL and testbench
===================================

// Module: ccd_pixel_packer
// PURPOSE
//  Downstream of ccd_readout: captures AD9826 byte stream (MSB then LSB per pixel), assembles 16-bit pixels.
//  Tags pixels with frame/row headers and buffers them in an internal FIFO.
//  Serialises the buffer into bytes on the clk-side write port of the tx fifo feeding ft245.
//  Runs independently of tx_mux.
// PARAMETERS
//  BUF_AW    6      log2 depth of internal entry buffer (64 x 18-bit entries)
//  HDR_FRAME 8'hF0  header byte of frame packet
//  HDR_ROW   8'hF1  header byte of row packet
// PORTS
//  clk          in   1   system clock (100 MHz)
//  rst_n        in   1   synchronous active-low reset
//  enable       in   1   capture enable; low = ignore frame_start/row_start/ad_strobe
//  frame_start  in   1   1-cycle pulse, start of CCD frame
//  row_start    in   1   1-cycle pulse, start of CCD row
//  ad_strobe    in   1   1-cycle pulse, ad_data valid this cycle
//  ad_data      in   8   AD9826 output byte
//  wfull        in   1   tx fifo full, active high
//  wdata        out  8   byte to tx fifo
//  winc         out  1   tx fifo write strobe
//  overflow     out  1   sticky: an entry was dropped on full buffer
//  row_count    out  16  rows started in current frame
//  busy         out  1   buffer non-empty or serialiser not IDLE
// BEHAVIOUR
//  Reset: wdata=0, winc=0, overflow=0, row_count=0, busy=0; buffer empty; frame_count=0; byte phase=MSB; FSM=IDLE.
//  Entry format {tag[1:0],data[15:0]}: 00 pixel, 01 row hdr (data=row index), 10 frame hdr (data=frame_count). Tag 11 unused.
//  Capture (enable=1), at most one push per cycle:
//   - frame_start: push frame hdr; then frame_count++ (wraps FFFF->0); row_count=0; overflow cleared; phase=MSB.
//     Coincident row_start/ad_strobe ignored.
//   - row_start (no frame_start): push row hdr with row_count; then row_count++ (wraps); phase=MSB.
//     Coincident ad_strobe ignored. A held MSB is discarded.
//   - ad_strobe, phase MSB: latch byte, phase=LSB. No push.
//   - ad_strobe, phase LSB: push pixel {msb,ad_data}; phase=MSB.
//  Push while buffer full: entry dropped, overflow=1 next cycle. Buffer contents unchanged.
//  enable=0: no pushes, no counter/phase changes. Serialiser keeps draining.
//  Serialiser FSM:
//   - IDLE -> POP when buffer non-empty.
//   - POP: read entry into holding reg (1 cycle).
//   - B0: hdr byte (tag 01/10) or pixel MSB (tag 00).
//   - B1: hdr data[15:8] or pixel LSB.
//   - B2 (hdr only): data[7:0].
//   - After last byte: -> POP if buffer non-empty, else IDLE.
//  Byte state output: wdata=current byte. winc = in byte state && !wfull (combinational on wfull).
//  State advances only on a cycle with winc=1. wfull=1 stalls: state and wdata held, no byte lost or duplicated.
//  Latency: push in cycle N -> first winc earliest N+2. Pixel = 2 bytes; header = 3 bytes.
//  Throughput: 2 bytes per 3 cycles sustained (POP bubble). The buffer absorbs bursts.
//  Simultaneous push and pop on the same entry slot is legal. A push on a full buffer in the pop cycle is still dropped.
//  Full = (wptr-rptr)==2^BUF_AW. Pointers are BUF_AW+1 bits and wrap naturally.
//  rst_n=0 mid-packet: packet abandoned, winc=0 the same edge, buffer flushed.
// TESTING
//  1. frame_start, row_start, 4 strobes 12,34,56,78; wfull=0 -> bytes F0 00 00, F1 00 00, 12 34, 56 78; row_count=1.
//  2. Same as 1 with wfull=1 for 10 cycles during row hdr byte 2 -> identical byte stream, winc=0 while full.
//  3. wfull=1, push 65 pixels -> overflow=1, 64 pixels out after release; next frame_start clears overflow.
//  4. Strobe AB, then row_start, then strobes CD,EF -> AB discarded; stream F1 00 nn, CD EF.
//  5. frame_start+row_start+ad_strobe same cycle -> only frame hdr pushed, row_count=0, phase=MSB.
//  6. rst_n low during pixel LSB stall -> winc=0, busy=0, overflow=0, frame_count=0 after reset.

Source files
------------

// File: rtl/ccd_pixel_packer.sv
// Assembles AD9826 byte pairs into 16-bit pixels, tags frame/row headers, buffers and serialises to bytes.
// Latency: capture in cycle N gives the first tx byte in cycle N+2 at the earliest; pixel = 2 bytes, header = 3 bytes.
// Backpressure: wfull stalls the serialiser with no byte lost; a push into a full buffer is dropped and flags overflow.
module ccd_pixel_packer #(
    parameter int         BUF_AW    = 6,
    parameter logic [7:0] HDR_FRAME = 8'hF0,
    parameter logic [7:0] HDR_ROW   = 8'hF1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        frame_start,
    input  logic        row_start,
    input  logic        ad_strobe,
    input  logic [7:0]  ad_data,
    input  logic        wfull,
    output logic [7:0]  wdata,
    output logic        winc,
    output logic        overflow,
    output logic [15:0] row_count,
    output logic        busy
);

    localparam logic [BUF_AW:0] FULL_CNT = {1'b1, {BUF_AW{1'b0}}};
    localparam logic [BUF_AW:0] PTR_ONE  = {{BUF_AW{1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_POP, S_B0, S_B1, S_B2} state_t;

    // Entry buffer: {tag[1:0], data[15:0]}, tag 00 pixel, 01 row header, 10 frame header
    logic [17:0]       mem [0:(1<<BUF_AW)-1];
    logic [BUF_AW:0]   wptr, rptr;
    logic [BUF_AW:0]   fill;
    logic              buf_full, buf_empty;

    logic [15:0]       frame_count;
    logic              phase_lsb;
    logic [7:0]        msb_q;

    logic              push_req, push_ok, push_drop;
    logic [17:0]       push_dat;

    state_t            state, state_nxt;
    logic [17:0]       hold;
    logic              hold_hdr;
    logic              has_work;

    assign fill      = wptr - rptr;
    assign buf_full  = (fill == FULL_CNT);
    assign buf_empty = (wptr == rptr);
    assign hold_hdr  = |hold[17:16];

    // Capture decode: frame_start outranks row_start, which outranks ad_strobe
    always_comb begin
        push_req = 1'b0;
        push_dat = '0;
        if (enable) begin
            if (frame_start) begin
                push_req = 1'b1;
                push_dat = {2'b10, frame_count};
            end else if (row_start) begin
                push_req = 1'b1;
                push_dat = {2'b01, row_count};
            end else if (ad_strobe && phase_lsb) begin
                push_req = 1'b1;
                push_dat = {2'b00, msb_q, ad_data};
            end
        end
    end

    // Full check uses the pre-pop fill so a push into a full buffer drops even while popping
    assign push_ok   = push_req && !buf_full;
    assign push_drop = push_req && buf_full;
    // Work visible to the serialiser includes the entry being written this cycle
    assign has_work  = !buf_empty || push_ok;

    // Capture state: counters, byte phase, held MSB and sticky overflow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_count <= '0;
            row_count   <= '0;
            phase_lsb   <= 1'b0;
            msb_q       <= '0;
            overflow    <= 1'b0;
        end else begin
            if (enable) begin
                if (frame_start) begin
                    frame_count <= frame_count + 16'd1;
                    row_count   <= '0;
                    phase_lsb   <= 1'b0;
                end else if (row_start) begin
                    row_count   <= row_count + 16'd1;
                    phase_lsb   <= 1'b0;
                end else if (ad_strobe) begin
                    if (!phase_lsb) begin
                        msb_q     <= ad_data;
                        phase_lsb <= 1'b1;
                    end else begin
                        phase_lsb <= 1'b0;
                    end
                end
            end
            // A drop in the same cycle as frame_start still reports overflow
            if (push_drop) begin
                overflow <= 1'b1;
            end else if (enable && frame_start) begin
                overflow <= 1'b0;
            end
        end
    end

    // Buffer storage; contents after reset are irrelevant because the pointers flush it
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wptr[BUF_AW-1:0]] <= push_dat;
        end
    end

    // Buffer pointers and holding register loaded in the POP state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            hold <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + PTR_ONE;
            end
            if (state == S_POP) begin
                hold <= mem[rptr[BUF_AW-1:0]];
                rptr <= rptr + PTR_ONE;
            end
        end
    end

    // Serialiser state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Serialiser next state; leaving IDLE waits for wfull low so a stalled tx fifo keeps the full buffer depth
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (has_work && !wfull) state_nxt = S_POP;
            S_POP:  state_nxt = S_B0;
            S_B0:   if (winc) state_nxt = S_B1;
            S_B1:   if (winc) state_nxt = hold_hdr ? S_B2 : (has_work ? S_POP : S_IDLE);
            S_B2:   if (winc) state_nxt = has_work ? S_POP : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Serialiser outputs: byte select per state, write strobe gated combinationally by wfull
    always_comb begin
        wdata = '0;
        winc  = 1'b0;
        case (state)
            S_B0: begin
                wdata = hold_hdr ? (hold[17] ? HDR_FRAME : HDR_ROW) : hold[15:8];
                winc  = !wfull;
            end
            S_B1: begin
                wdata = hold_hdr ? hold[15:8] : hold[7:0];
                winc  = !wfull;
            end
            S_B2: begin
                wdata = hold[7:0];
                winc  = !wfull;
            end
            default: begin
                wdata = '0;
                winc  = 1'b0;
            end
        endcase
    end

    assign busy = !buf_empty || (state != S_IDLE);

endmodule

// File: tb/tb_ccd_pixel_packer.sv
// Bench for ccd_pixel_packer: table vectors, hand sequences and randomized traffic.
// Expected bytes come from a packet-level model (queue of bytes built from the capture rules).
// wfull is driven by the bench to exercise stalls and overflow.
module tb_ccd_pixel_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        frame_start = 1'b0;
    logic        row_start = 1'b0;
    logic        ad_strobe = 1'b0;
    logic [7:0]  ad_data = 8'h00;
    logic        wfull = 1'b0;
    logic [7:0]  wdata;
    logic        winc;
    logic        overflow;
    logic [15:0] row_count;
    logic        busy;

    ccd_pixel_packer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .frame_start (frame_start),
        .row_start   (row_start),
        .ad_strobe   (ad_strobe),
        .ad_data     (ad_data),
        .wfull       (wfull),
        .wdata       (wdata),
        .winc        (winc),
        .overflow    (overflow),
        .row_count   (row_count),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int bytes_seen = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_log[$];

    // Packet-level reference state
    logic [15:0] m_fc, m_rc;
    logic [7:0]  m_msb;
    bit          m_lsb, m_ovf;
    int          m_pushes;

    typedef struct {
        bit          en, fs, rs, st;
        logic [7:0]  d;
        logic [15:0] exp_rc;
    } vec_t;
    vec_t tbl[14];

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endfunction

    task automatic model_reset();
        m_fc = '0; m_rc = '0; m_msb = '0; m_lsb = 0; m_ovf = 0;
        exp_q.delete();
    endtask

    task automatic model_entry(input logic [1:0] tag, input logic [15:0] d, input bit keep);
        m_pushes++;
        if (!keep) begin
            m_ovf = 1;
        end else begin
            if (tag == 2'b10) exp_q.push_back(8'hF0);
            if (tag == 2'b01) exp_q.push_back(8'hF1);
            exp_q.push_back(d[15:8]);
            exp_q.push_back(d[7:0]);
        end
    endtask

    task automatic model_cycle(input bit en_i, fs_i, rs_i, st_i, input logic [7:0] d_i, input bit keep);
        if (en_i) begin
            if (fs_i) begin
                m_ovf = 0;
                model_entry(2'b10, m_fc, keep);
                m_fc = m_fc + 16'd1;
                m_rc = 16'd0;
                m_lsb = 0;
            end else if (rs_i) begin
                model_entry(2'b01, m_rc, keep);
                m_rc = m_rc + 16'd1;
                m_lsb = 0;
            end else if (st_i) begin
                if (!m_lsb) begin
                    m_msb = d_i;
                    m_lsb = 1;
                end else begin
                    model_entry(2'b00, {m_msb, d_i}, keep);
                    m_lsb = 0;
                end
            end
        end
    endtask

    // One capture cycle: drive, advance, then compare the capture-side outputs
    task automatic apply(input bit en_i, fs_i, rs_i, st_i, input logic [7:0] d_i, input bit keep);
        enable = en_i; frame_start = fs_i; row_start = rs_i; ad_strobe = st_i; ad_data = d_i;
        model_cycle(en_i, fs_i, rs_i, st_i, d_i, keep);
        @(posedge clk); #1;
        frame_start = 0; row_start = 0; ad_strobe = 0; enable = 1;
        check("row_count", {16'd0, row_count}, {16'd0, m_rc});
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    endtask

    task automatic wait_idle(input string nm);
        bit done = 0;
        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            if (!busy) begin done = 1; break; end
        end
        check({nm, "_idle"}, {31'd0, done}, 32'd1);
        check({nm, "_drained"}, exp_q.size(), 32'd0);
    endtask

    task automatic wait_bytes(input int target);
        bit done = 0;
        for (int i = 0; i < 2000; i++) begin
            if (bytes_seen >= target) begin done = 1; break; end
            @(posedge clk); #1;
        end
        check("wait_bytes", {31'd0, done}, 32'd1);
    endtask

    // Byte monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (rst_n && winc) begin
            got_log.push_back(wdata);
            bytes_seen++;
            if (exp_q.size() == 0) begin
                check("unexpected_byte", {24'd0, wdata}, 32'hFFFF_FFFF);
            end else begin
                check("tx_byte", {24'd0, wdata}, {24'd0, exp_q.pop_front()});
            end
        end
        if (rst_n && wfull) begin
            check("winc_while_full", {31'd0, winc}, 32'd0);
        end
    end

    initial begin
        logic [7:0] t1_bytes [10];
        int base;
        t1_bytes = '{8'hF0, 8'h00, 8'h00, 8'hF1, 8'h00, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78};

        tbl[0]  = '{1, 1, 0, 0, 8'h00, 16'd0};
        tbl[1]  = '{1, 0, 1, 0, 8'h00, 16'd1};
        tbl[2]  = '{1, 0, 0, 1, 8'h12, 16'd1};
        tbl[3]  = '{1, 0, 0, 1, 8'h34, 16'd1};
        tbl[4]  = '{1, 0, 0, 1, 8'h56, 16'd1};
        tbl[5]  = '{1, 0, 0, 1, 8'h78, 16'd1};
        tbl[6]  = '{1, 0, 0, 1, 8'hAB, 16'd1};
        tbl[7]  = '{1, 0, 1, 0, 8'h00, 16'd2};
        tbl[8]  = '{1, 0, 0, 1, 8'hCD, 16'd2};
        tbl[9]  = '{1, 0, 0, 1, 8'hEF, 16'd2};
        tbl[10] = '{0, 0, 1, 0, 8'h00, 16'd2};
        tbl[11] = '{0, 0, 0, 1, 8'h99, 16'd2};
        tbl[12] = '{1, 0, 0, 1, 8'h42, 16'd2};
        tbl[13] = '{1, 0, 0, 1, 8'h24, 16'd2};

        // Reset state
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_wdata", {24'd0, wdata}, 32'd0);
        check("rst_winc", {31'd0, winc}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_row_count", {16'd0, row_count}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1; enable = 1;
        @(posedge clk); #1;

        // Table: basic frame/row/pixel stream, then discarded MSB and enable=0 rows
        got_log.delete();
        for (int i = 0; i < 6; i++) begin
            apply(tbl[i].en, tbl[i].fs, tbl[i].rs, tbl[i].st, tbl[i].d, 1);
            check("tbl_rc", {16'd0, row_count}, {16'd0, tbl[i].exp_rc});
        end
        wait_idle("t1");
        check("t1_len", got_log.size(), 32'd10);
        for (int i = 0; i < 10 && i < got_log.size(); i++) begin
            check("t1_byte", {24'd0, got_log[i]}, {24'd0, t1_bytes[i]});
        end
        for (int i = 6; i < 14; i++) begin
            apply(tbl[i].en, tbl[i].fs, tbl[i].rs, tbl[i].st, tbl[i].d, 1);
            check("tbl_rc", {16'd0, row_count}, {16'd0, tbl[i].exp_rc});
        end
        wait_idle("t4");

        // Latency: push in cycle N, no byte in N+1, first byte in N+2
        apply(1, 0, 1, 0, 8'h00, 1);
        @(negedge clk);
        check("lat_n1", {31'd0, winc}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("lat_n2", {31'd0, winc}, 32'd1);
        wait_idle("lat");

        // Stall during the row header
        base = bytes_seen;
        apply(1, 1, 0, 0, 8'h00, 1);
        apply(1, 0, 1, 0, 8'h00, 1);
        apply(1, 0, 0, 1, 8'h12, 1);
        apply(1, 0, 0, 1, 8'h34, 1);
        apply(1, 0, 0, 1, 8'h56, 1);
        apply(1, 0, 0, 1, 8'h78, 1);
        wait_bytes(base + 4);
        wfull = 1;
        repeat (10) begin @(posedge clk); #1; end
        wfull = 0;
        wait_idle("t2");
        check("t2_count", bytes_seen - base, 32'd10);

        // Overflow: 65 pixels into a stalled tx fifo, 64 survive
        base = bytes_seen;
        wfull = 1;
        for (int i = 0; i < 130; i++) apply(1, 0, 0, 1, 8'($urandom), i < 128);
        check("t3_ovf", {31'd0, overflow}, 32'd1);
        check("t3_busy", {31'd0, busy}, 32'd1);
        wfull = 0;
        wait_idle("t3");
        check("t3_count", bytes_seen - base, 32'd128);
        apply(1, 1, 0, 0, 8'h00, 1);
        check("t3_ovf_clr", {31'd0, overflow}, 32'd0);
        wait_idle("t3b");

        // Frame, row and strobe together: only the frame header
        got_log.delete();
        apply(1, 1, 1, 1, 8'h77, 1);
        check("t5_rc", {16'd0, row_count}, 32'd0);
        apply(1, 0, 0, 1, 8'h11, 1);
        apply(1, 0, 0, 1, 8'h22, 1);
        wait_idle("t5");
        check("t5_len", got_log.size(), 32'd5);
        if (got_log.size() == 5) begin
            check("t5_hdr", {24'd0, got_log[0]}, 32'hF0);
            check("t5_pix_msb", {24'd0, got_log[3]}, 32'h11);
            check("t5_pix_lsb", {24'd0, got_log[4]}, 32'h22);
        end

        // Randomized traffic with bounded occupancy per round
        for (int r = 0; r < 5; r++) begin
            m_pushes = 0;
            for (int c = 0; c < 2000 && m_pushes < 40; c++) begin
                wfull = ($urandom % 4) == 0;
                apply(($urandom % 8) != 0, ($urandom % 40) == 0, ($urandom % 15) == 0,
                      ($urandom % 3) == 0, 8'($urandom), 1);
            end
            wfull = 0;
            wait_idle("rnd");
        end

        // Reset in the middle of a stalled pixel with overflow set
        wfull = 1;
        for (int i = 0; i < 130; i++) apply(1, 0, 0, 1, 8'($urandom), i < 128);
        check("t6_ovf_set", {31'd0, overflow}, 32'd1);
        base = bytes_seen;
        wfull = 0;
        wait_bytes(base + 1);
        wfull = 1;
        @(posedge clk); #1;
        rst_n = 0;
        model_reset();
        @(posedge clk); #1;
        check("t6_winc", {31'd0, winc}, 32'd0);
        check("t6_busy", {31'd0, busy}, 32'd0);
        check("t6_ovf", {31'd0, overflow}, 32'd0);
        check("t6_rc", {16'd0, row_count}, 32'd0);
        rst_n = 1; wfull = 0;
        got_log.delete();
        apply(1, 1, 0, 0, 8'h00, 1);
        wait_idle("t6");
        check("t6_len", got_log.size(), 32'd3);
        if (got_log.size() == 3) begin
            check("t6_fc_hi", {24'd0, got_log[1]}, 32'd0);
            check("t6_fc_lo", {24'd0, got_log[2]}, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
